// File: rtl/pu_msp430_pkg.sv
// rtl/pu_msp430_pkg.sv - shared types and constants for the msp430 program-memory helpers
package pu_msp430_pkg;

  localparam int PMEM_LDR_SUM_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WR   = 3'd3,
    RD   = 3'd4,
    CHK  = 3'd5
  } pmem_ldr_state_t;

endpackage

// File: rtl/pu_msp430_pmem_loader.sv
// rtl/pu_msp430_pmem_loader.sv - byte-stream loader into program memory port B with optional checksum read-back
module pu_msp430_pmem_loader
  import pu_msp430_pkg::*;
#(
  parameter int ADDR_MSB = 11,
  parameter int VERIFY   = 1
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                start,
  input  logic [ADDR_MSB:0]   base_addr,
  input  logic [ADDR_MSB+1:0] word_cnt,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                ram_en,
  output logic [1:0]          ram_we,
  output logic [ADDR_MSB:0]   ram_addr,
  output logic [15:0]         ram_din,
  input  logic [15:0]         ram_dout,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CW = ADDR_MSB + 2;
  typedef logic [PMEM_LDR_SUM_W-1:0] sum_t;

  pmem_ldr_state_t r_state, w_state_nxt;
  logic [ADDR_MSB:0] r_base, w_base_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [CW-1:0]     r_i, w_i_nxt;
  logic [CW-1:0]     r_j, w_j_nxt;
  logic [7:0]        r_lo, w_lo_nxt;
  logic [7:0]        r_hi, w_hi_nxt;
  sum_t              r_wsum, w_wsum_nxt;
  sum_t              r_rsum, w_rsum_nxt;
  logic              r_rd_pend, w_rd_pend_nxt;
  logic              r_ram_en, w_ram_en_nxt;
  logic [1:0]        r_ram_we, w_ram_we_nxt;
  logic [ADDR_MSB:0] r_ram_addr, w_ram_addr_nxt;
  logic [15:0]       r_ram_din, w_ram_din_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;

  logic              w_hs;
  logic [CW-1:0]     w_i_inc;
  logic [ADDR_MSB:0] w_wr_addr;
  logic [ADDR_MSB:0] w_rd_addr;
  sum_t              w_rsum_acc;

  assign s_ready    = (r_state == LO) || (r_state == HI);
  assign w_hs       = s_valid & s_ready;
  assign w_i_inc    = r_i + CW'(1);
  assign w_wr_addr  = r_base + r_i[ADDR_MSB:0];
  assign w_rd_addr  = r_base + r_j[ADDR_MSB:0];
  // Read data lands one cycle after its request; fold it in whenever a read is outstanding.
  assign w_rsum_acc = r_rd_pend ? (r_rsum + ram_dout) : r_rsum;

  always_comb begin
    w_state_nxt    = r_state;
    w_base_nxt     = r_base;
    w_cnt_nxt      = r_cnt;
    w_i_nxt        = r_i;
    w_j_nxt        = r_j;
    w_lo_nxt       = r_lo;
    w_hi_nxt       = r_hi;
    w_wsum_nxt     = r_wsum;
    w_rsum_nxt     = w_rsum_acc;
    w_rd_pend_nxt  = 1'b0;
    w_ram_en_nxt   = 1'b0;
    w_ram_we_nxt   = 2'b00;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_din_nxt  = r_ram_din;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = r_err;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_base_nxt = base_addr;
          w_cnt_nxt  = word_cnt;
          w_i_nxt    = '0;
          w_j_nxt    = '0;
          w_wsum_nxt = '0;
          w_rsum_nxt = '0;
          w_err_nxt  = 1'b0;
          if (word_cnt == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = LO;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      LO: begin
        if (w_hs) begin
          w_lo_nxt    = s_data;
          w_state_nxt = HI;
        end
      end
      HI: begin
        // Outputs are registered, so the write is set up here to appear during WR.
        if (w_hs) begin
          w_hi_nxt       = s_data;
          w_state_nxt    = WR;
          w_ram_en_nxt   = 1'b1;
          w_ram_we_nxt   = 2'b11;
          w_ram_addr_nxt = w_wr_addr;
          w_ram_din_nxt  = {s_data, r_lo};
          if ((VERIFY == 0) && (w_i_inc == r_cnt)) begin
            w_done_nxt = 1'b1;
          end
        end
      end
      WR: begin
        w_wsum_nxt = r_wsum + {r_hi, r_lo};
        w_i_nxt    = w_i_inc;
        if (w_i_inc == r_cnt) begin
          if (VERIFY != 0) begin
            w_state_nxt    = RD;
            w_ram_en_nxt   = 1'b1;
            w_ram_addr_nxt = r_base;
            w_j_nxt        = CW'(1);
          end else begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_state_nxt = LO;
        end
      end
      RD: begin
        w_rd_pend_nxt = 1'b1;
        if (r_j == r_cnt) begin
          w_state_nxt = CHK;
          w_done_nxt  = 1'b1;
        end else begin
          w_ram_en_nxt   = 1'b1;
          w_ram_addr_nxt = w_rd_addr;
          w_j_nxt        = r_j + CW'(1);
        end
      end
      CHK: begin
        w_err_nxt   = (w_rsum_acc != r_wsum);
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_cnt      <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_wsum     <= '0;
      r_rsum     <= '0;
      r_rd_pend  <= 1'b0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 2'b00;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_base     <= w_base_nxt;
      r_cnt      <= w_cnt_nxt;
      r_i        <= w_i_nxt;
      r_j        <= w_j_nxt;
      r_lo       <= w_lo_nxt;
      r_hi       <= w_hi_nxt;
      r_wsum     <= w_wsum_nxt;
      r_rsum     <= w_rsum_nxt;
      r_rd_pend  <= w_rd_pend_nxt;
      r_ram_en   <= w_ram_en_nxt;
      r_ram_we   <= w_ram_we_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_din  <= w_ram_din_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign ram_en   = r_ram_en;
  assign ram_we   = r_ram_we;
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule
